div_seq_nat_int: RTL and testbench
==================================

// Module: div_seq_nat_int
// PURPOSE
//  Sequential restoring divider for naturals or integers in base 2, N-bit operands, one quotient bit per clock.
//  Sequential companion to the combinational standard networks. Used where a datapath needs x/y and x%y
//  without an N-stage combinational array. Start/finish is a soc/eoc handshake; sgn selects natural/integer.
// PARAMETERS
//  N   8   operand, quotient and remainder width in bits (N >= 2)
// PORTS
//  clock    in   1   single clock, all state updates on rising edge
//  reset_   in   1   asynchronous, active-low reset
//  soc      in   1   start of conversion; request from producer
//  sgn      in   1   0 = naturals, 1 = integers (two's complement); sampled with operands
//  x        in   N   dividend; sampled when the start is accepted
//  y        in   N   divisor; sampled when the start is accepted
//  eoc      out  1   end of conversion; 1 = idle/result valid, 0 = busy
//  q        out  N   quotient (registered)
//  r        out  N   remainder (registered)
//  dbz      out  1   division by zero on last operation
//  ovf      out  1   integer overflow on last operation (-2^(N-1) / -1)
// BEHAVIOUR
//  Reset (reset_=0, async): state S_IDLE, eoc=1, q=0, r=0, dbz=0, ovf=0, iteration counter 0.
//  States: S_IDLE -> S_PREP -> S_ITER (N cycles) -> S_FIX -> S_DONE -> S_IDLE.
//  S_IDLE: eoc=1. On edge with soc=1: latch x,y,sgn into internal regs, eoc<=0, go S_PREP.
//  S_PREP: if sgn=1, take magnitudes of x,y (negate if MSB=1); record sign_q = x[N-1]^y[N-1], sign_r = x[N-1].
//          If sgn=0, magnitudes = raw operands, signs = 0. Flag dbz_i = (y==0), ovf_i = sgn & x==10..0 & y==1..1.
//          Load partial remainder P=0 (N+1 bits), shift reg A=|x|, counter=N-1; go S_ITER.
//  S_ITER: one restoring step per cycle: {P,A} <<= 1; T = P - {0,|y|} on N+1 bits; if T>=0 then P=T, A[0]=1
//          else A[0]=0. After counter==0 step, go S_FIX. Always exactly N iterations (fixed latency).
//  S_FIX:  q <= sign_q ? -A : A; r <= sign_r ? -P[N-1:0] : P[N-1:0] (truncation toward zero,
//          remainder takes dividend sign). Overrides: dbz_i -> q=all ones, r=x as latched, dbz=1;
//          ovf_i -> q=10..0 (=x), r=0, ovf=1. Else dbz=ovf=0. eoc<=1; go S_DONE.
//  S_DONE: eoc=1, outputs held. Stay while soc=1; go S_IDLE on soc=0 (no restart while soc held high).
//  Latency: eoc rises N+2 rising edges after the edge that accepted soc (N=8: 10 edges).
//  q,r,dbz,ovf change only in S_FIX (and on reset); they hold through S_IDLE and the next busy period.
//  x,y,sgn,soc changes while eoc=0 are ignored. Unsigned arithmetic: |x| of 10..0 is 10..0 as natural.
//  reset_ asserted mid-operation: immediate abort to reset values above; no partial result visible.
//  No combinational path from inputs to outputs.
// STRUCTURE
//  Shared header (reti_standard include): state encodings S_IDLE..S_DONE as localparams, width of
//  counter as $clog2(N). No other shared constants.
//  One sub-module: div_step -- combinational, N+1-bit trial subtract + select; inputs P, A msb, |y|;
//  outputs next P and quotient bit. Negations in S_PREP/S_FIX built on the team's standard adder.
// TESTING (N=8)
//  1 sgn=0, x=200, y=7, soc pulse -> after 10 edges eoc=1, q=28, r=4, dbz=0, ovf=0.
//  2 sgn=1, x=8'hF9(-7), y=2 -> q=8'hFD(-3), r=8'hFF(-1); sgn=1, x=7, y=8'hFE(-2) -> q=8'hFD, r=1.
//  3 sgn=1, x=8'h80, y=8'hFF -> q=8'h80, r=0, ovf=1; then sgn=0 same operands -> q=0, r=8'h80, ovf=0.
//  4 sgn=0, x=13, y=0 -> q=8'hFF, r=13, dbz=1; next op 9/3 -> q=3, r=0, dbz cleared.
//  5 reset_=0 during 4th S_ITER cycle -> eoc=1, q=r=0 at once; after release new op 100/10 -> q=10, r=0.
//  6 soc held high past completion, x,y toggled while busy -> single result from latched operands, no restart
//    until soc=0 then soc=1.

Source files
------------

// File: rtl/div_seq_nat_int_pkg.sv
// Shared types for the sequential restoring divider.
package div_seq_nat_int_pkg;

    // Controller states; S_ITER runs exactly N cycles, so latency is fixed.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/div_seq_nat_int_if.sv
// Start/finish handshake plus operand and result bus of the divider.
interface div_seq_nat_int_if #(parameter int N = 8);
    logic         soc;
    logic         sgn;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         eoc;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    logic         ovf;

    modport master (output soc, sgn, x, y, input eoc, q, r, dbz, ovf);
    modport slave  (input soc, sgn, x, y, output eoc, q, r, dbz, ovf);
endinterface

// File: rtl/div_seq_nat_int_step.sv
// One restoring division step: shift in the next dividend bit, trial
// subtract the divisor magnitude, keep the difference if it is non-negative.
module div_seq_nat_int_step #(parameter int N = 8) (
    input  logic [N:0]   p,
    input  logic         a_msb,
    input  logic [N-1:0] ym,
    output logic [N:0]   p_nxt,
    output logic         qbit
);
    logic [N+1:0] sh;
    logic [N+1:0] t;

    // One extra bit on the trial difference so its sign is always exact.
    always_comb begin
        sh    = {p, a_msb};
        t     = sh - {2'b00, ym};
        qbit  = ~t[N+1];
        p_nxt = qbit ? t[N:0] : sh[N:0];
    end
endmodule

// File: rtl/div_seq_nat_int.sv
// Sequential restoring divider, natural or two's-complement operands,
// one quotient bit per clock, soc/eoc handshake, registered results.
module div_seq_nat_int
    import div_seq_nat_int_pkg::*;
#(
    parameter int N = 8
) (
    input logic              clock,
    input logic              reset_,
    div_seq_nat_int_if.slave bus
);
    localparam int           CW   = $clog2(N);
    localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    function automatic logic [N-1:0] neg(input logic [N-1:0] v);
        return ~v + {{(N-1){1'b0}}, 1'b1};
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  x_q, x_d, y_q, y_d;
    logic          sgn_q, sgn_d;
    logic [N-1:0]  a_q, a_d, ym_q, ym_d;
    logic [N:0]    p_q, p_d;
    logic          qneg_q, qneg_d, rneg_q, rneg_d;
    logic          dbz_i_q, dbz_i_d, ovf_i_q, ovf_i_d;
    logic [N-1:0]  q_q, q_d, r_q, r_d;
    logic          dbz_q, dbz_d, ovf_q, ovf_d, eoc_q, eoc_d;
    logic [N:0]    p_nxt;
    logic          qbit;

    div_seq_nat_int_step #(.N(N)) u_step (
        .p     (p_q),
        .a_msb (a_q[N-1]),
        .ym    (ym_q),
        .p_nxt (p_nxt),
        .qbit  (qbit)
    );

    // Next-state and datapath updates for the handshake controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        ym_d    = ym_q;
        p_d     = p_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_i_d = dbz_i_q;
        ovf_i_d = ovf_i_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        eoc_d   = eoc_q;
        case (state_q)
            S_IDLE: begin
                eoc_d = 1'b1;
                if (bus.soc) begin
                    x_d     = bus.x;
                    y_d     = bus.y;
                    sgn_d   = bus.sgn;
                    eoc_d   = 1'b0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                qneg_d  = sgn_q & (x_q[N-1] ^ y_q[N-1]);
                rneg_d  = sgn_q & x_q[N-1];
                a_d     = (sgn_q && x_q[N-1]) ? neg(x_q) : x_q;
                ym_d    = (sgn_q && y_q[N-1]) ? neg(y_q) : y_q;
                dbz_i_d = (y_q == '0);
                ovf_i_d = sgn_q && (x_q == MINV) && (y_q == '1);
                p_d     = '0;
                cnt_d   = CW'(N - 1);
                state_d = S_ITER;
            end
            S_ITER: begin
                p_d = p_nxt;
                a_d = {a_q[N-2:0], qbit};
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_FIX: begin
                // Overrides take priority; zero divisor wins over overflow.
                if (dbz_i_q) begin
                    q_d = '1;
                    r_d = x_q;
                end else if (ovf_i_q) begin
                    q_d = MINV;
                    r_d = '0;
                end else begin
                    q_d = qneg_q ? neg(a_q) : a_q;
                    r_d = rneg_q ? neg(p_q[N-1:0]) : p_q[N-1:0];
                end
                dbz_d   = dbz_i_q;
                ovf_d   = ovf_i_q & ~dbz_i_q;
                eoc_d   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                eoc_d = 1'b1;
                if (!bus.soc) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            ym_q    <= '0;
            p_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_i_q <= 1'b0;
            ovf_i_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            eoc_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            ym_q    <= ym_d;
            p_q     <= p_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_i_q <= dbz_i_d;
            ovf_i_q <= ovf_i_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            eoc_q   <= eoc_d;
        end
    end

    assign bus.eoc = eoc_q;
    assign bus.q   = q_q;
    assign bus.r   = r_q;
    assign bus.dbz = dbz_q;
    assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_div_seq_nat_int.sv
// Bench for div_seq_nat_int (N=8): directed cases plus random operands
// checked against a plain-arithmetic reference.
module tb_div_seq_nat_int;
    logic clock;
    logic reset_;
    int   checks = 0;
    int   errors = 0;

    div_seq_nat_int_if #(.N(8)) bus ();

    div_seq_nat_int #(.N(8)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: truncating division, remainder follows the dividend.
    task automatic model(input logic s, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] eq, output logic [7:0] er,
                         output logic ed, output logic eo);
        int sa, sb;
        ed = 1'b0;
        eo = 1'b0;
        if (b == 8'd0) begin
            eq = 8'hFF; er = a; ed = 1'b1;
        end else if (s && a == 8'h80 && b == 8'hFF) begin
            eq = 8'h80; er = 8'h00; eo = 1'b1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            eq = 8'(sa / sb);
            er = 8'(sa % sb);
        end else begin
            eq = a / b;
            er = a % b;
        end
    endtask

    // Start one op from idle, scramble the operands after acceptance,
    // and count rising edges until eoc returns.
    task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clock); bus.soc = 1'b0;
        @(negedge clock);
        bus.sgn = s; bus.x = a; bus.y = b; bus.soc = 1'b1;
        @(posedge clock); #1;
        bus.soc = 1'b0; bus.x = ~a; bus.y = b + 8'd1; bus.sgn = ~s;
        lat = 0;
        while (bus.eoc !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        checks++; if (bus.eoc !== 1'b1) begin errors++; $display("FAIL reset_eoc got %b exp 1", bus.eoc); end
        checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", bus.q); end
        checks++; if (bus.r !== 8'h00) begin errors++; $display("FAIL reset_r got %h exp 00", bus.r); end
        checks++; if (bus.dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", bus.dbz); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.ovf); end
    endtask

    task automatic test_natural;
        int lat;
        do_op(1'b0, 8'd200, 8'd7, lat);
        checks++; if (lat != 10) begin errors++; $display("FAIL nat_latency got %0d exp 10", lat); end
        checks++; if ({bus.q, bus.r} !== {8'd28, 8'd4}) begin errors++; $display("FAIL nat_200_7 got q=%0d r=%0d exp q=28 r=4", bus.q, bus.r); end
        checks++; if ({bus.dbz, bus.ovf} !== 2'b00) begin errors++; $display("FAIL nat_flags got %b%b exp 00", bus.dbz, bus.ovf); end
    endtask

    task automatic test_signed;
        int lat;
        do_op(1'b1, 8'hF9, 8'h02, lat);
        checks++; if ({bus.q, bus.r} !== {8'hFD, 8'hFF}) begin errors++; $display("FAIL sgn_m7_2 got q=%h r=%h exp q=fd r=ff", bus.q, bus.r); end
        do_op(1'b1, 8'h07, 8'hFE, lat);
        checks++; if ({bus.q, bus.r} !== {8'hFD, 8'h01}) begin errors++; $display("FAIL sgn_7_m2 got q=%h r=%h exp q=fd r=01", bus.q, bus.r); end
    endtask

    task automatic test_overflow;
        int lat;
        do_op(1'b1, 8'h80, 8'hFF, lat);
        checks++; if ({bus.q, bus.r, bus.ovf, bus.dbz} !== {8'h80, 8'h00, 1'b1, 1'b0}) begin errors++; $display("FAIL ovf_signed got q=%h r=%h ovf=%b dbz=%b exp 80 00 1 0", bus.q, bus.r, bus.ovf, bus.dbz); end
        do_op(1'b0, 8'h80, 8'hFF, lat);
        checks++; if ({bus.q, bus.r, bus.ovf} !== {8'h00, 8'h80, 1'b0}) begin errors++; $display("FAIL ovf_natural got q=%h r=%h ovf=%b exp 00 80 0", bus.q, bus.r, bus.ovf); end
    endtask

    task automatic test_dbz;
        int lat;
        do_op(1'b0, 8'd13, 8'd0, lat);
        checks++; if ({bus.q, bus.r, bus.dbz} !== {8'hFF, 8'd13, 1'b1}) begin errors++; $display("FAIL dbz_13_0 got q=%h r=%h dbz=%b exp ff 0d 1", bus.q, bus.r, bus.dbz); end
        checks++; if (lat != 10) begin errors++; $display("FAIL dbz_latency got %0d exp 10", lat); end
        do_op(1'b0, 8'd9, 8'd3, lat);
        checks++; if ({bus.q, bus.r, bus.dbz} !== {8'd3, 8'd0, 1'b0}) begin errors++; $display("FAIL dbz_clear got q=%h r=%h dbz=%b exp 03 00 0", bus.q, bus.r, bus.dbz); end
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clock); bus.soc = 1'b0;
        @(negedge clock);
        bus.sgn = 1'b0; bus.x = 8'd50; bus.y = 8'd3; bus.soc = 1'b1;
        @(posedge clock); #1; bus.soc = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock); reset_ = 1'b0; #1;
        checks++; if ({bus.eoc, bus.q, bus.r, bus.dbz, bus.ovf} !== {1'b1, 8'h00, 8'h00, 2'b00}) begin errors++; $display("FAIL midreset got eoc=%b q=%h r=%h dbz=%b ovf=%b exp 1 00 00 0 0", bus.eoc, bus.q, bus.r, bus.dbz, bus.ovf); end
        @(negedge clock); reset_ = 1'b1;
        do_op(1'b0, 8'd100, 8'd10, lat);
        checks++; if ({bus.q, bus.r} !== {8'd10, 8'd0}) begin errors++; $display("FAIL after_reset got q=%0d r=%0d exp 10 0", bus.q, bus.r); end
        checks++; if (lat != 10) begin errors++; $display("FAIL after_reset_latency got %0d exp 10", lat); end
    endtask

    task automatic test_hold;
        int  lat;
        logic dropped;
        @(negedge clock); bus.soc = 1'b0;
        @(negedge clock);
        bus.sgn = 1'b0; bus.x = 8'd50; bus.y = 8'd7; bus.soc = 1'b1;
        @(posedge clock); #1;
        lat = 0;
        while (bus.eoc !== 1'b1 && lat < 40) begin
            bus.x = 8'($urandom); bus.y = 8'($urandom); bus.sgn = 1'($urandom);
            @(posedge clock); #1;
            lat++;
        end
        checks++; if ({bus.q, bus.r, lat} !== {8'd7, 8'd1, 32'd10}) begin errors++; $display("FAIL hold_result got q=%0d r=%0d lat=%0d exp 7 1 10", bus.q, bus.r, lat); end
        bus.sgn = 1'b0; bus.x = 8'd60; bus.y = 8'd7;
        dropped = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            if (bus.eoc !== 1'b1 || bus.q !== 8'd7) dropped = 1'b1;
        end
        checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL hold_no_restart got restart=%b exp 0", dropped); end
        @(negedge clock); bus.soc = 1'b0;
        @(negedge clock); bus.soc = 1'b1;
        @(posedge clock); #1;
        checks++; if (bus.eoc !== 1'b0) begin errors++; $display("FAIL hold_restart_accept got eoc=%b exp 0", bus.eoc); end
        bus.soc = 1'b0;
        lat = 0;
        while (bus.eoc !== 1'b1 && lat < 40) begin @(posedge clock); #1; lat++; end
        checks++; if ({bus.q, bus.r} !== {8'd8, 8'd4}) begin errors++; $display("FAIL hold_second got q=%0d r=%0d exp 8 4", bus.q, bus.r); end
    endtask

    task automatic test_random;
        int lat;
        logic s, ed, eo;
        logic [7:0] a, b, eq, er;
        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 7))
                0: b = 8'd0;
                1: begin a = 8'h80; b = 8'hFF; end
                2: b = 8'($urandom_range(1, 4));
                default: ;
            endcase
            model(s, a, b, eq, er, ed, eo);
            do_op(s, a, b, lat);
            checks++;
            if ({bus.q, bus.r, bus.dbz, bus.ovf, lat} !== {eq, er, ed, eo, 32'd10}) begin
                errors++;
                $display("FAIL rand sgn=%b x=%h y=%h got q=%h r=%h dbz=%b ovf=%b lat=%0d exp q=%h r=%h dbz=%b ovf=%b lat=10",
                         s, a, b, bus.q, bus.r, bus.dbz, bus.ovf, lat, eq, er, ed, eo);
            end
        end
    endtask

    initial begin
        reset_  = 1'b0;
        bus.soc = 1'b0;
        bus.sgn = 1'b0;
        bus.x   = 8'd0;
        bus.y   = 8'd0;
        repeat (3) @(negedge clock);
        test_reset;
        reset_ = 1'b1;
        test_natural;
        test_signed;
        test_overflow;
        test_dbz;
        test_reset_mid;
        test_hold;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
